// File: rtl/sample_packer.sv
// Packs a stream of N-bit samples into WIDTH_VECTOR-lane vectors and pushes them into the core input FIFO.
// A fill register and a one-entry output buffer together hold at most two complete vectors under backpressure.
module sample_packer #(
  parameter int WIDTH_VECTOR = 16,
  parameter int N            = 16,
  parameter int WC           = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [N-1:0]              s_data,
  input  logic                      s_last,
  output logic [WIDTH_VECTOR*N-1:0] fifo_wdata,
  output logic                      fifo_winc,
  input  logic                      fifo_full,
  output logic [WC-1:0]             vec_cnt,
  output logic                      pad_flag
);

  localparam int LW = $clog2(WIDTH_VECTOR);
  localparam int VW = WIDTH_VECTOR * N;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_HELD    = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lane_idx;
  logic [VW-1:0]   r_fill;
  logic            r_fill_pad;
  logic            r_out_valid;
  logic [VW-1:0]   r_out_data;
  logic            r_out_pad;
  logic [WC-1:0]   r_vec_cnt;

  logic            w_accept;
  logic            w_push;
  logic            w_out_free;
  logic            w_last_lane;
  logic            w_complete;
  logic            w_done_pad;
  logic [VW-1:0]   w_fill_wr;
  logic            w_load_fill;
  logic            w_load_held;
  logic            w_hold;

  // s_ready is a pure function of the FSM state, so upstream never sees a combinational path back from s_valid.
  assign s_ready     = (r_state == ST_FILLING);
  assign w_accept    = s_valid & s_ready;
  assign w_push      = r_out_valid & ~fifo_full;
  assign w_out_free  = ~r_out_valid | w_push;
  assign w_last_lane = (r_lane_idx == LW'(WIDTH_VECTOR - 1));
  assign w_complete  = w_accept & (w_last_lane | s_last);
  assign w_done_pad  = s_last & ~w_last_lane;

  assign fifo_wdata  = r_out_data;
  assign fifo_winc   = w_push;
  assign pad_flag    = r_out_pad & r_out_valid;
  assign vec_cnt     = r_vec_cnt;

  // Fill contents including the sample being accepted; lanes above it are already zero,
  // which is what makes an early s_last come out zero-padded.
  always_comb begin
    w_fill_wr = r_fill;
    for (int i = 0; i < WIDTH_VECTOR; i++) begin
      if (r_lane_idx == LW'(i)) w_fill_wr[i*N +: N] = s_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_FILLING;
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_load_fill = 1'b0;
    w_load_held = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      ST_FILLING: begin
        if (w_complete) begin
          if (w_out_free) begin
            w_load_fill = 1'b1;
          end else begin
            w_hold      = 1'b1;
            w_state_nxt = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (w_out_free) begin
          w_load_held = 1'b1;
          w_state_nxt = ST_FILLING;
        end
      end
      default: w_state_nxt = ST_FILLING;
    endcase
  end

  // NOTE: the vector registers are reset on purpose: the outputs must read zero during reset
  // and a reset must discard any partial or held vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane_idx <= '0;
      r_fill     <= '0;
      r_fill_pad <= 1'b0;
    end else if (w_load_fill || w_load_held) begin
      r_lane_idx <= '0;
      r_fill     <= '0;
      r_fill_pad <= 1'b0;
    end else if (w_hold) begin
      r_fill     <= w_fill_wr;
      r_fill_pad <= w_done_pad;
    end else if (w_accept) begin
      r_fill     <= w_fill_wr;
      r_lane_idx <= r_lane_idx + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_pad   <= 1'b0;
    end else if (w_load_fill) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fill_wr;
      r_out_pad   <= w_done_pad;
    end else if (w_load_held) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_fill;
      r_out_pad   <= r_fill_pad;
    end else if (w_push) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_vec_cnt <= '0;
    else if (w_push) r_vec_cnt <= r_vec_cnt + WC'(1);
  end

  a_stable_when_full: assert property (@(posedge clk) disable iff (!rstn)
    (r_out_valid && fifo_full) |=> $stable(r_out_data));

  a_no_accept_in_held: assert property (@(posedge clk) disable iff (!rstn)
    (r_state == ST_HELD) |-> !w_accept);

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer: a lane model queues expected vectors as samples are accepted,
// and a negedge monitor pops and compares them whenever the DUT pushes.
module tb_sample_packer;
  localparam int WV = 16;
  localparam int N  = 16;
  localparam int VW = WV * N;

  typedef struct packed {
    logic [VW-1:0] data;
    logic          pad;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [N-1:0]  s_data = '0;
  logic          fifo_full = 1'b0;

  logic          s_ready, s_ready_w4;
  logic [VW-1:0] fifo_wdata, fifo_wdata_w4;
  logic          fifo_winc, fifo_winc_w4;
  logic [15:0]   vec_cnt;
  logic [3:0]    vec_cnt_w4;
  logic          pad_flag, pad_flag_w4;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            n_push = 0;
  int            push_cyc[$];
  vec_t          exp_q[$];
  logic [VW-1:0] m_fill = '0;
  int            m_idx = 0;
  logic [15:0]   exp_cnt = '0;

  sample_packer #(.WIDTH_VECTOR(WV), .N(N), .WC(16)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc),
    .fifo_full(fifo_full), .vec_cnt(vec_cnt), .pad_flag(pad_flag)
  );

  sample_packer #(.WIDTH_VECTOR(WV), .N(N), .WC(4)) dut_w4 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_w4), .s_data(s_data),
    .s_last(s_last), .fifo_wdata(fifo_wdata_w4), .fifo_winc(fifo_winc_w4),
    .fifo_full(fifo_full), .vec_cnt(vec_cnt_w4), .pad_flag(pad_flag_w4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every push must match the oldest expected vector.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (rstn === 1'b1 && fifo_winc === 1'b1) begin
      n_push++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_push got=%h", fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (fifo_wdata !== e.data) begin
          failures++;
          $display("FAIL push_data got=%h exp=%h", fifo_wdata, e.data);
        end
        checks++;
        if (pad_flag !== e.pad) begin
          failures++;
          $display("FAIL push_pad got=%b exp=%b", pad_flag, e.pad);
        end
        checks++;
        if (vec_cnt !== exp_cnt) begin
          failures++;
          $display("FAIL push_vec_cnt got=%0d exp=%0d", vec_cnt, exp_cnt);
        end
        checks++;
        if (fifo_winc_w4 !== 1'b1 || fifo_wdata_w4 !== e.data) begin
          failures++;
          $display("FAIL push_w4 winc=%b data=%h exp=%h", fifo_winc_w4, fifo_wdata_w4, e.data);
        end
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic model_accept(input logic [N-1:0] d, input logic last);
    vec_t v;
    m_fill[m_idx*N +: N] = d;
    if (last || m_idx == WV - 1) begin
      v.data = m_fill;
      v.pad  = last && (m_idx < WV - 1);
      exp_q.push_back(v);
      m_fill = '0;
      m_idx  = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_fill  = '0;
    m_idx   = 0;
    exp_cnt = '0;
  endtask

  // Offers one sample until an edge where s_ready was high; returns the number of stalled edges.
  task automatic send(input logic [N-1:0] d, input logic last, output int waits);
    bit ok;
    bit done;
    waits = 0;
    done  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!done) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        model_accept(d, last);
        done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          checks++; failures++;
          $display("FAIL send_timeout data=%h", d);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    fifo_full = 1'b0;
    rstn = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d exp=0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b0) begin failures++; $display("FAIL reset_winc got=%b exp=0", fifo_winc); end
    checks++;
    if (pad_flag !== 1'b0) begin failures++; $display("FAIL reset_pad got=%b exp=0", pad_flag); end
    checks++;
    if (vec_cnt !== 16'd0) begin failures++; $display("FAIL reset_vec_cnt got=%0d exp=0", vec_cnt); end
    checks++;
    if (fifo_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", fifo_wdata); end
    checks++;
    if (vec_cnt_w4 !== 4'd0) begin failures++; $display("FAIL reset_vec_cnt_w4 got=%0d exp=0", vec_cnt_w4); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_full_vector();
    int w, tot;
    logic [N-1:0] lane;
    tot = 0;
    for (int i = 0; i < WV; i++) begin
      send(N'(i + 1), 1'b0, w);
      tot += w;
    end
    idle();
    @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b1) begin failures++; $display("FAIL full_latency winc=%b exp=1", fifo_winc); end
    lane = fifo_wdata[15*N +: N];
    checks++;
    if (lane !== 16'd16) begin failures++; $display("FAIL full_lane15 got=%h exp=0010", lane); end
    @(posedge clk);
    #1;
    wait_drain("full");
    checks++;
    if (tot != 0) begin failures++; $display("FAIL full_stalls got=%0d exp=0", tot); end
    checks++;
    if (vec_cnt !== 16'd1) begin failures++; $display("FAIL full_vec_cnt got=%0d exp=1", vec_cnt); end
  endtask

  task automatic test_padded();
    int w;
    logic [N-1:0] lane;
    send(16'h000A, 1'b0, w);
    send(16'h000B, 1'b0, w);
    send(16'h000C, 1'b1, w);
    idle();
    @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b1 || pad_flag !== 1'b1) begin
      failures++;
      $display("FAIL pad_push winc=%b pad=%b exp=1,1", fifo_winc, pad_flag);
    end
    lane = fifo_wdata[3*N +: N];
    checks++;
    if (lane !== 16'h0000) begin failures++; $display("FAIL pad_lane3 got=%h exp=0000", lane); end
    @(negedge clk);
    checks++;
    if (pad_flag !== 1'b0) begin failures++; $display("FAIL pad_after_push got=%b exp=0", pad_flag); end
    @(posedge clk);
    #1;
    // s_last on the final lane is an ordinary full vector.
    for (int i = 0; i < WV; i++) send(N'(16'h0050 + i), (i == WV - 1), w);
    idle();
    @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b1 || pad_flag !== 1'b0) begin
      failures++;
      $display("FAIL last_on_final winc=%b pad=%b exp=1,0", fifo_winc, pad_flag);
    end
    @(posedge clk);
    #1;
    wait_drain("pad");
  endtask

  task automatic test_backpressure();
    int w, tot;
    logic [VW-1:0] snap;
    do_reset();
    fifo_full = 1'b1;
    tot = 0;
    for (int i = 1; i <= 32; i++) begin
      send(N'(i), 1'b0, w);
      tot += w;
    end
    checks++;
    if (tot != 0) begin failures++; $display("FAIL bp_fill_stalls got=%0d exp=0", tot); end
    s_valid = 1'b1;
    s_data  = 16'd33;
    s_last  = 1'b0;
    @(negedge clk);
    snap = fifo_wdata;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (s_ready !== 1'b0 || fifo_winc !== 1'b0 || fifo_wdata !== snap) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d s_ready=%b winc=%b stable=%b exp=0,0,1",
                 k, s_ready, fifo_winc, (fifo_wdata === snap));
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    push_cyc.delete();
    fifo_full = 1'b0;
    send(16'd33, 1'b0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL bp_s33_stall got=%0d exp=1", w); end
    checks++;
    if (push_cyc.size() != 2 || push_cyc[1] != push_cyc[0] + 1) begin
      failures++;
      $display("FAIL bp_consecutive pushes=%0d exp=2 back-to-back", push_cyc.size());
    end
    for (int i = 34; i <= 40; i++) send(N'(i), (i == 40), w);
    idle();
    wait_drain("bp");
    checks++;
    if (vec_cnt !== 16'd3) begin failures++; $display("FAIL bp_vec_cnt got=%0d exp=3", vec_cnt); end
  endtask

  task automatic test_back_to_back();
    int w, tot;
    do_reset();
    push_cyc.delete();
    tot = 0;
    for (int i = 0; i < 48; i++) begin
      send(N'(16'h0200 + i), 1'b0, w);
      tot += w;
    end
    idle();
    wait_drain("b2b");
    checks++;
    if (tot != 0) begin failures++; $display("FAIL b2b_stalls got=%0d exp=0", tot); end
    checks++;
    if (push_cyc.size() != 3) begin
      failures++;
      $display("FAIL b2b_push_count got=%0d exp=3", push_cyc.size());
    end else begin
      checks++;
      if (push_cyc[1] - push_cyc[0] != 16 || push_cyc[2] - push_cyc[1] != 16) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d,%0d exp=16,16",
                 push_cyc[1] - push_cyc[0], push_cyc[2] - push_cyc[1]);
      end
    end
    checks++;
    if (vec_cnt !== 16'd3) begin failures++; $display("FAIL b2b_vec_cnt got=%0d exp=3", vec_cnt); end
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    for (int i = 0; i < 17 * WV; i++) send(N'($urandom), 1'b0, w);
    idle();
    wait_drain("wrap");
    checks++;
    if (vec_cnt !== 16'd17) begin failures++; $display("FAIL wrap_vec_cnt16 got=%0d exp=17", vec_cnt); end
    checks++;
    if (vec_cnt_w4 !== 4'd1) begin failures++; $display("FAIL wrap_vec_cnt4 got=%0d exp=1", vec_cnt_w4); end
  endtask

  task automatic test_reset_mid();
    int w, base;
    do_reset();
    for (int i = 0; i < 7; i++) send(N'(16'h0100 + i), 1'b0, w);
    idle();
    base = n_push;
    rstn = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_push != base) begin failures++; $display("FAIL rmid_partial_push got=%0d exp=0", n_push - base); end
    for (int i = 0; i < WV; i++) send(N'(16'h0300 + i), 1'b0, w);
    idle();
    wait_drain("rmid");
    checks++;
    if (vec_cnt !== 16'd1) begin failures++; $display("FAIL rmid_vec_cnt got=%0d exp=1", vec_cnt); end
    // Reset while one vector sits in the output buffer and another is held.
    fifo_full = 1'b1;
    for (int i = 0; i < 2 * WV; i++) send(N'(16'h0400 + i), 1'b0, w);
    idle();
    base = n_push;
    rstn = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    fifo_full = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_push != base) begin failures++; $display("FAIL rheld_push got=%0d exp=0", n_push - base); end
    checks++;
    if (vec_cnt !== 16'd0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL rheld_state vec_cnt=%0d s_ready=%b exp=0,1", vec_cnt, s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_padded();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter WIDTH_VECTOR, default 16: lanes per vector; SHALL be a power of 2, 2..64.
REQ-002 Parameter N, default 16: bits per sample (lane width).
REQ-003 Parameter WC, default 16: width of the pushed-vector counter.
REQ-004 Ports: clk input 1: rising-edge clock; also drives the core's fifo_wclk.
REQ-005 Ports: rstn input 1: reset, asynchronous, active-low.
REQ-006 Ports: s_valid input 1: upstream sample valid.
REQ-007 Ports: s_ready output 1: block accepts a sample this cycle.
REQ-008 Ports: s_data input N: sample value.
REQ-009 Ports: s_last input 1: sample closes the current vector early; qualified by s_valid.
REQ-010 Ports: fifo_wdata output WIDTH_VECTOR*N: packed vector; lane i occupies bits [i*N +: N].
REQ-011 Ports: fifo_winc output 1: push strobe to the core input FIFO.
REQ-012 Ports: fifo_full input 1: core input FIFO full.
REQ-013 Ports: vec_cnt output WC: number of vectors pushed, modulo 2^WC.
REQ-014 Ports: pad_flag output 1: vector currently held in the output buffer was zero-padded.

Function
REQ-015 A sample is accepted when s_valid and s_ready are both 1 on a rising clk edge.
REQ-016 Fill register: an accepted sample SHALL be written into lane lane_idx, and lane_idx SHALL increment, starting at 0.
REQ-017 Fill completes when the accepted sample has lane_idx == WIDTH_VECTOR-1, or has s_last=1.
REQ-018 On an s_last completion at lane k < WIDTH_VECTOR-1, lanes k+1..WIDTH_VECTOR-1 SHALL be 0 and the vector marked padded.
REQ-019 Fill FSM states:
- FILLING (s_ready=1).
- HELD (complete vector waiting; s_ready=0).
REQ-020 Output buffer (out_valid, out_data, out_pad):
- fifo_wdata = out_data.
- pad_flag = out_pad & out_valid.
REQ-021 fifo_winc SHALL equal out_valid & ~fifo_full, combinationally; out_valid clears on a push unless reloaded in the same cycle.
REQ-022 Transfer fill to output when the output buffer is free, i.e. ~out_valid or a push this cycle. Transfer occurs:
- on the completing edge itself, or
- from HELD, returning to FILLING.
On transfer, lane_idx resets to 0 and the fill lanes clear to 0.
REQ-023 Completing while the output buffer is not free: FSM enters HELD; no sample is accepted until the transfer.
REQ-024 Latency: completing sample accepted at edge t, output free -> fifo_winc=1 in the cycle after t (fifo_full=0).
REQ-025 Throughput: sustained 1 sample/cycle when fifo_full=0; no bubble at vector boundaries.
REQ-026 fifo_wdata SHALL be stable while out_valid=1 and fifo_full=1.
REQ-027 vec_cnt increments by 1 on each cycle with fifo_winc=1 and wraps from 2^WC-1 to 0.
REQ-028 s_last at lane_idx == WIDTH_VECTOR-1 is a normal full vector; pad_flag=0.
REQ-029 fifo_full asserted indefinitely: at most 2 vectors are buffered (output + HELD); no data is lost or overwritten.
REQ-030 s_ready SHALL depend only on registered state, not on s_valid.

Reset
REQ-031 While rstn=0, all of the following SHALL be 0, with the FSM in FILLING:
- lane_idx, fill lanes, out_valid, out_data, out_pad, vec_cnt;
- fifo_winc, pad_flag.
REQ-032 s_ready SHALL be 1 from the first rising edge after rstn deasserts.
REQ-033 Reset mid-vector or mid-HELD SHALL discard partial and held data; no fifo_winc is issued for it.

Verification
REQ-034 WV=16, N=16, fifo_full=0, samples 1..16 back-to-back:
- one fifo_winc in the cycle after sample 16;
- lane i = i+1; pad_flag=0; vec_cnt=1.
REQ-035 Samples 0xA,0xB,0xC with s_last on 0xC -> lanes 0..2 = A,B,C, lanes 3..15 = 0, pad_flag=1 during the push.
REQ-036 fifo_full=1 held, 40 samples offered:
- s_ready drops after sample 32; fifo_winc=0 throughout.
- On release, two consecutive pushes of vectors 1..16 and 17..32; then sample 33 is accepted.
REQ-037 48 continuous samples with fifo_full=0 -> s_ready stays 1; 3 pushes, 16 cycles apart; vec_cnt=3.
REQ-038 WC=4, 17 vectors pushed -> vec_cnt = 1 (wrap).
REQ-039 rstn pulsed low after 7 samples -> no push; the next 16 samples form a clean vector with lane 0 = first post-reset sample.
